serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder.sv | 17 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and WIDTH legality limits for the bit-serial adder.
// Imported by the adder top; the full-adder cell needs nothing from here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full-adder cell, purely combinational (zero latency, no handshake).
// Addition-side mirror of the ripple subtractor cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial a+b+c_in, LSB first through one full-adder cell; result valid WIDTH cycles after accept.
// Operands accepted only in IDLE; result held in DONE until out_ready, then one IDLE cycle.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  if (!width_ok(WIDTH)) begin : g_width_illegal
    $error("serial_adder: WIDTH must be within 2..32");
  end

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  // Only the upper WIDTH-1 partial sum bits need storage; the last bit
  // comes straight from the cell when the result register is loaded.
  logic [WIDTH-1:1] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cmsb;
  logic             fa_s, fa_co;
  logic             accept, retire, last_bit;

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q, ovf_q;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c_in (carry),
    .s    (fa_s),
    .c_out(fa_co)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign last_bit  = (state_q == ST_RUN) && (cnt == CNT_LAST);
  assign sum_nxt   = {fa_s, sum_sh};

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (retire)   state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cmsb    <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            cmsb  <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_sh <= sum_nxt[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
          if (cnt == CNT_MSB)  cmsb <= fa_co;
          // cmsb already holds the carry into the MSB from the previous cycle.
          if (last_bit) begin
            sum_q   <= sum_nxt;
            c_out_q <= fa_co;
            ovf_q   <= cmsb ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 with hand-computed vectors.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and returns once out_valid is seen; lat = edges from accept, -1 on timeout.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        output int lat);
    int wait_cyc;
    wait_cyc = 0;
    lat = -1;
    while (!in_ready && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    if (in_ready) begin
      a = ai; b = bi; c_in = ci; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
        tick();
        lat++;
      end
      if (!out_valid) lat = -1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum, c_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b, want 1 0 00 0 0",
               in_ready, out_valid, sum, c_out, ovf);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] va[5]  = '{8'h5A, 8'hFF, 8'h7F, 8'h80, 8'hFF};
    logic [W-1:0] vb[5]  = '{8'h3C, 8'h01, 8'h00, 8'h80, 8'hFF};
    logic         vc[5]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [W-1:0] vs[5]  = '{8'h96, 8'h00, 8'h80, 8'h00, 8'hFF};
    logic         vco[5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic         vov[5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], lat);
      vectors++;
      if (lat !== W) begin
        miscompares++;
        $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, W);
      end
      vectors++;
      if ({sum, c_out, ovf} !== {vs[i], vco[i], vov[i]}) begin
        miscompares++;
        $display("FAIL basic_result[%0d]: %h+%h+%b got sum=%h c_out=%b ovf=%b want %h %b %b",
                 i, va[i], vb[i], vc[i], sum, c_out, ovf, vs[i], vco[i], vov[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL basic_retire[%0d]: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(8'h33, 8'h44, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({out_valid, sum, c_out, ovf} !== {1'b1, 8'h78, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b sum=%h c_out=%b ovf=%b want 1 78 0 0",
                 i, out_valid, sum, c_out, ovf);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 8'h78}) begin
      miscompares++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b sum=%h want 1 0 78",
               in_ready, out_valid, sum);
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    a = 8'h12; b = 8'h34; c_in = 1'b1; in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 100) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    vectors++;
    if (lat !== W) begin
      miscompares++;
      $display("FAIL ignore_latency: got %0d want %0d", lat, W);
    end
    vectors++;
    if ({sum, c_out, ovf} !== {8'h47, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_result: sum=%h c_out=%b ovf=%b want 47 0 0", sum, c_out, ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    a = 8'hAA; b = 8'h55; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b sum=%h want 1 0 00", in_ready, out_valid, sum);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_result: out_valid seen=%b want 0", seen);
    end
    run_op(8'h01, 8'h01, 1'b0, lat);
    vectors++;
    if ({sum, c_out, ovf} !== {8'h02, 1'b0, 1'b0} || lat !== W) begin
      miscompares++;
      $display("FAIL reset_mid_after: sum=%h c_out=%b ovf=%b lat=%0d want 02 0 0 %0d",
               sum, c_out, ovf, lat, W);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] q[$];
    logic [2*W:0] op;
    logic [W:0]   full;
    logic         exp_ovf;
    int retired, cyc, last_acc, n_acc;
    retired = 0; cyc = 0; last_acc = 0; n_acc = 0;
    while (retired < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      c_in      = 1'($urandom);
      out_ready = 1'($urandom);
      if (in_valid && in_ready) begin
        if (n_acc > 0) begin
          vectors++;
          if (cyc - last_acc < W + 2) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d want >= %0d", cyc - last_acc, W + 2);
          end
        end
        q.push_back({a, b, c_in});
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: result %h with no operation outstanding", sum);
        end else begin
          op = q.pop_front();
          full = {1'b0, op[2*W:W+1]} + {1'b0, op[W:1]} + {{W{1'b0}}, op[0]};
          exp_ovf = (op[2*W] == op[W]) && (full[W-1] != op[2*W]);
          if ({sum, c_out, ovf} !== {full[W-1:0], full[W], exp_ovf}) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: %h+%h+%b got %h %b %b want %h %b %b", retired,
                     op[2*W:W+1], op[W:1], op[0], sum, c_out, ovf, full[W-1:0], full[W], exp_ovf);
          end
        end
        retired++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (retired != 1000) begin
      miscompares++;
      $display("FAIL b2b_timeout: retired %0d want 1000", retired);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
